// File: rtl/if_tune_ctrl.sv
// IF synthesizer tuning sequencer: clamps requests, issues the frequency strobe, and qualifies lock with timeout/retry.
// Defining IF_TUNE_SCAN_EN adds scan_en_i / SCAN_DWELL auto-stepping of the tuned frequency.
//
// state     | meaning
// IDLE      | tune settled (or lost after unlock); accepting requests
// STROBE    | one-cycle freq_strobe for the current if_freq
// BLANK     | synthesizer reconfiguring; locked ignored, timeout running
// WAIT_LOCK | counting consecutive locked cycles, timeout running
// FAULT     | every attempt timed out; accepting requests
module if_tune_ctrl #(
  parameter int unsigned F_MIN       = 1,
  parameter int unsigned F_MAX       = 511,
  parameter int unsigned F_INIT      = 7,
  parameter int unsigned BLANK_CYC   = 16,
  parameter int unsigned STABLE_CYC  = 64,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned MAX_RETRY   = 3
`ifdef IF_TUNE_SCAN_EN
  , parameter int unsigned SCAN_DWELL = 1000
`endif
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req_valid_i,
  input  logic [8:0] req_freq_i,
  output logic       req_ready_o,
  output logic [8:0] if_freq_o,
  output logic       freq_strobe_o,
  input  logic       locked_i,
`ifdef IF_TUNE_SCAN_EN
  input  logic       scan_en_i,
`endif
  output logic       tuned_o,
  output logic       busy_o,
  output logic       fault_o
);

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    BLANK,
    WAIT_LOCK,
    FAULT
  } state_t;

  localparam logic [8:0]  FMIN_W   = 9'(F_MIN);
  localparam logic [8:0]  FMAX_W   = 9'(F_MAX);
  localparam logic [8:0]  FINIT_W  = 9'(F_INIT);
  localparam logic [7:0]  BLANK_LD = 8'(BLANK_CYC - 1);
  localparam logic [7:0]  STABLE_W = 8'(STABLE_CYC);
  localparam logic [19:0] TMO_LD   = 20'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  RETRY_W  = 8'(MAX_RETRY);

  state_t      state_q, state_d;
  logic [8:0]  if_freq_q, if_freq_d;
  logic        strobe_q, strobe_d;
  logic        tuned_q, tuned_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  blank_q, blank_d;
  logic [19:0] tmo_q, tmo_d;
  logic [7:0]  run_q, run_d;
  logic [7:0]  unlk_q, unlk_d;

  logic        accept;
  logic        new_req;
  logic [8:0]  clamp_f;
  logic [8:0]  new_f;

`ifdef IF_TUNE_SCAN_EN
  localparam logic [31:0] DWELL_LD = 32'(SCAN_DWELL - 1);
  logic [31:0] dwell_q, dwell_d;
  logic [8:0]  scan_f;

  assign scan_f = (if_freq_q >= FMAX_W) ? FMIN_W : (if_freq_q + 9'd1);
`endif

  assign req_ready_o   = (state_q == IDLE) || (state_q == FAULT);
  assign busy_o        = (state_q == STROBE) || (state_q == BLANK) || (state_q == WAIT_LOCK);
  assign fault_o       = (state_q == FAULT);
  assign if_freq_o     = if_freq_q;
  assign freq_strobe_o = strobe_q;
  assign tuned_o       = tuned_q;
  assign accept        = req_valid_i && req_ready_o;

  always_comb begin
    clamp_f = req_freq_i;
    if (req_freq_i < FMIN_W) begin
      clamp_f = FMIN_W;
    end else if (req_freq_i > FMAX_W) begin
      clamp_f = FMAX_W;
    end
  end

  // External accept first; the scan dwell may only self-issue when nothing was accepted.
  always_comb begin
    new_req = accept;
    new_f   = clamp_f;
`ifdef IF_TUNE_SCAN_EN
    dwell_d = DWELL_LD;
    if (!accept && (state_q == IDLE) && tuned_q && scan_en_i) begin
      if (dwell_q == 32'd0) begin
        new_req = 1'b1;
        new_f   = scan_f;
      end else begin
        dwell_d = dwell_q - 32'd1;
      end
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    if_freq_d = if_freq_q;
    strobe_d  = 1'b0;
    tuned_d   = tuned_q;
    retry_d   = retry_q;
    blank_d   = blank_q;
    tmo_d     = tmo_q;
    run_d     = run_q;
    unlk_d    = unlk_q;

    case (state_q)
      IDLE: begin
        if (locked_i) begin
          unlk_d = 8'd0;
        end else if (tuned_q) begin
          if (unlk_q == STABLE_W - 8'd1) begin
            tuned_d = 1'b0;
            unlk_d  = 8'd0;
          end else begin
            unlk_d = unlk_q + 8'd1;
          end
        end
        if (new_req && !(tuned_q && (new_f == if_freq_q))) begin
          if_freq_d = new_f;
          tuned_d   = 1'b0;
          retry_d   = 8'd0;
          unlk_d    = 8'd0;
          strobe_d  = 1'b1;
          state_d   = STROBE;
        end
      end

      FAULT: begin
        unlk_d = 8'd0;
        if (new_req) begin
          if_freq_d = new_f;
          tuned_d   = 1'b0;
          retry_d   = 8'd0;
          strobe_d  = 1'b1;
          state_d   = STROBE;
        end
      end

      // Coming out of reset the strobe register is still low, so STROBE holds one extra cycle to raise it.
      STROBE: begin
        blank_d = BLANK_LD;
        tmo_d   = TMO_LD;
        run_d   = 8'd0;
        if (strobe_q) begin
          state_d = BLANK;
        end else begin
          strobe_d = 1'b1;
        end
      end

      BLANK: begin
        if (tmo_q == 20'd0) begin
          if (retry_q < RETRY_W) begin
            retry_d  = retry_q + 8'd1;
            strobe_d = 1'b1;
            state_d  = STROBE;
          end else begin
            state_d = FAULT;
          end
        end else begin
          tmo_d = tmo_q - 20'd1;
          if (blank_q == 8'd0) begin
            state_d = WAIT_LOCK;
          end else begin
            blank_d = blank_q - 8'd1;
          end
        end
      end

      WAIT_LOCK: begin
        run_d = locked_i ? (run_q + 8'd1) : 8'd0;
        if (locked_i && (run_q == STABLE_W - 8'd1)) begin
          tuned_d = 1'b1;
          unlk_d  = 8'd0;
          state_d = IDLE;
        end else if (tmo_q == 20'd0) begin
          if (retry_q < RETRY_W) begin
            retry_d  = retry_q + 8'd1;
            strobe_d = 1'b1;
            state_d  = STROBE;
          end else begin
            state_d = FAULT;
          end
        end else begin
          tmo_d = tmo_q - 20'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= STROBE;
      if_freq_q <= FINIT_W;
      strobe_q  <= 1'b0;
      tuned_q   <= 1'b0;
      retry_q   <= 8'd0;
      blank_q   <= 8'd0;
      tmo_q     <= 20'd0;
      run_q     <= 8'd0;
      unlk_q    <= 8'd0;
`ifdef IF_TUNE_SCAN_EN
      dwell_q   <= 32'd0;
`endif
    end else begin
      state_q   <= state_d;
      if_freq_q <= if_freq_d;
      strobe_q  <= strobe_d;
      tuned_q   <= tuned_d;
      retry_q   <= retry_d;
      blank_q   <= blank_d;
      tmo_q     <= tmo_d;
      run_q     <= run_d;
      unlk_q    <= unlk_d;
`ifdef IF_TUNE_SCAN_EN
      dwell_q   <= dwell_d;
`endif
    end
  end

endmodule
